// File: rtl/tb_vector_seq.sv
// Vector sequencer: replays a loaded stimulus/expected table into a DUT and checks
// in-order responses, reporting a sticky ready (all passed) / error (first failure) pair.
module tb_vector_seq #(
    parameter int STIM_W  = 32,
    parameter int RESP_W  = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [STIM_W-1:0]          ld_stim,
    input  logic [RESP_W-1:0]          ld_exp,
    input  logic [RESP_W-1:0]          ld_mask,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_vec,
    output logic                       dut_valid,
    input  logic                       dut_ready,
    output logic [STIM_W-1:0]          dut_stim,
    input  logic                       dut_rvalid,
    input  logic [RESP_W-1:0]          dut_resp,
    output logic                       ready,
    output logic                       error,
    output logic [$clog2(DEPTH):0]     fail_idx,
    output logic [1:0]                 fail_code,
    output logic [1:0]                 dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] n_q, n_d;
    logic [IW-1:0] issue_q, issue_d;
    logic [IW-1:0] check_q, check_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic [IW-1:0] fail_idx_q, fail_idx_d;
    logic [1:0]    fail_code_q, fail_code_d;

    logic [STIM_W-1:0] stim_mem [DEPTH];
    logic [RESP_W-1:0] exp_mem  [DEPTH];
    logic [RESP_W-1:0] mask_mem [DEPTH];

    // Table survives reset; writes are only accepted while no run is active.
    always_ff @(posedge clk) begin
        if (ld_en && state_q != S_RUN) begin
            stim_mem[ld_addr] <= ld_stim;
            exp_mem[ld_addr]  <= ld_exp;
            mask_mem[ld_addr] <= ld_mask;
        end
    end

    // Issue channel: a stimulus transfers on any cycle with dut_valid & dut_ready;
    // while dut_valid is high and dut_ready low, dut_stim holds. Responses carry no
    // backpressure and must return in issue order, no earlier than the cycle after
    // the matching transfer.
    assign dut_valid   = (state_q == S_RUN) && (issue_q < n_q);
    assign dut_stim    = dut_valid ? stim_mem[issue_q[AW-1:0]] : '0;
    assign ready       = ready_q;
    assign error       = error_q;
    assign fail_idx    = fail_idx_q;
    assign fail_code   = fail_code_q;
    assign dbg_state_o = state_q;

    logic          fail;
    logic          pass;
    logic [1:0]    code;
    logic [RESP_W-1:0] diff;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        issue_d     = issue_q;
        check_d     = check_q;
        timer_d     = timer_q;
        ready_d     = ready_q;
        error_d     = error_q;
        fail_idx_d  = fail_idx_q;
        fail_code_d = fail_code_q;
        fail        = 1'b0;
        pass        = 1'b0;
        code        = 2'b00;
        diff        = (dut_resp ^ exp_mem[check_q[AW-1:0]]) & mask_mem[check_q[AW-1:0]];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d         = num_vec;
                    issue_d     = '0;
                    check_d     = '0;
                    timer_d     = '0;
                    ready_d     = 1'b0;
                    error_d     = 1'b0;
                    fail_idx_d  = '0;
                    fail_code_d = 2'b00;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (dut_valid && dut_ready) begin
                    issue_d = issue_q + IW'(1);
                end
                if (dut_rvalid) begin
                    timer_d = '0;
                    // issue_q only counts transfers from earlier edges, so a
                    // same-cycle response to a fresh transfer lands here too.
                    if (check_q >= issue_q || check_q == n_q) begin
                        fail = 1'b1;
                        code = 2'b11;
                    end else if (diff != '0) begin
                        fail = 1'b1;
                        code = 2'b01;
                    end else begin
                        check_d = check_q + IW'(1);
                        pass    = (check_q + IW'(1) == n_q);
                    end
                end else if (check_q == n_q) begin
                    pass = 1'b1;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    fail = 1'b1;
                    code = 2'b10;
                end else begin
                    timer_d = timer_q + TW'(1);
                end

                if (fail) begin
                    error_d     = 1'b1;
                    fail_idx_d  = check_q;
                    fail_code_d = code;
                    state_d     = S_DONE;
                end else if (pass) begin
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            issue_q     <= '0;
            check_q     <= '0;
            timer_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            fail_idx_q  <= '0;
            fail_code_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            issue_q     <= issue_d;
            check_q     <= check_d;
            timer_q     <= timer_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            fail_idx_q  <= fail_idx_d;
            fail_code_q <= fail_code_d;
        end
    end
endmodule

// File: tb/tb_tb_vector_seq.sv
// Directed bench for tb_vector_seq: an echo responder stands in for the unit under
// test, and each step checks hand-computed status, timing and issue order.
module tb_tb_vector_seq;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int AW      = 4;
    localparam int IW      = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_stim;
    logic [31:0]   ld_exp;
    logic [31:0]   ld_mask;
    logic          start;
    logic [IW-1:0] num_vec;
    logic          dut_valid;
    logic          dut_ready;
    logic [31:0]   dut_stim;
    logic          dut_rvalid;
    logic [31:0]   dut_resp;
    logic          ready;
    logic          error;
    logic [IW-1:0] fail_idx;
    logic [1:0]    fail_code;
    logic [1:0]    dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] stim_tbl [DEPTH];
    logic [31:0] exp_q [$];

    // Echo responder: one-cycle latency, stops answering after resp_limit responses.
    logic        m_rvalid;
    logic [31:0] m_resp;
    int          m_cnt;
    int          resp_limit;
    logic        force_rv;

    tb_vector_seq #(
        .STIM_W(32), .RESP_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim), .ld_exp(ld_exp), .ld_mask(ld_mask),
        .start(start), .num_vec(num_vec),
        .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_stim(dut_stim),
        .dut_rvalid(dut_rvalid), .dut_resp(dut_resp),
        .ready(ready), .error(error), .fail_idx(fail_idx), .fail_code(fail_code),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset || start) begin
            m_rvalid <= 1'b0;
            m_resp   <= '0;
            m_cnt    <= 0;
        end else begin
            m_rvalid <= dut_valid && dut_ready && (m_cnt < resp_limit);
            m_resp   <= dut_stim;
            if (dut_valid && dut_ready && (m_cnt < resp_limit)) m_cnt <= m_cnt + 1;
        end
    end

    assign dut_rvalid = m_rvalid | force_rv;
    assign dut_resp   = m_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] s, input logic [31:0] e, input logic [31:0] m);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_stim = s;
        ld_exp  = e;
        ld_mask = m;
        stim_tbl[a] = s;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Starts a run and samples each cycle at the falling edge; cycle 1 is the first RUN cycle.
    task automatic run(input int num, input bit toggle, input int max_cyc,
                       output int cyc, output int acc, output int vcyc);
        logic        prev_stall;
        logic [31:0] prev_stim;
        logic        done;
        exp_q.delete();
        for (int i = 0; i < num; i++) exp_q.push_back(stim_tbl[i]);
        @(negedge clk);
        num_vec   = IW'(num);
        start     = 1'b1;
        dut_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; acc = 0; vcyc = 0;
        prev_stall = 1'b0; prev_stim = '0; done = 1'b0;
        while (!done && cyc <= max_cyc) begin
            if (toggle) dut_ready = (cyc % 2 == 1);
            if (prev_stall) begin
                check("stall_hold_valid", dut_valid, 1);
                check("stall_hold_stim", dut_stim, prev_stim);
            end
            if (dut_valid) begin
                vcyc++;
                if (dut_ready) begin
                    if (exp_q.size() > 0) check("issue_stim", dut_stim, exp_q.pop_front());
                    else check("issue_extra", 1, 0);
                    acc++;
                end
            end
            prev_stall = dut_valid && !dut_ready;
            prev_stim  = dut_stim;
            if (ready || error) done = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        dut_ready = 1'b1;
        check("run_finished", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, acc, vcyc;
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_stim = '0; ld_exp = '0; ld_mask = '0;
        start = 1'b0; num_vec = '0; dut_ready = 1'b1; resp_limit = 1000; force_rv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", dut_valid, 0);
        check("rst_ready", ready, 0);
        check("rst_error", error, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_fail_code", fail_code, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            load(i, 32'hA500_0000 | (i * 32'h0011_0101), 32'hA500_0000 | (i * 32'h0011_0101), 32'hFFFF_FFFF);

        // Four echoed vectors: valid in cycles 1..4, ready in cycle 6.
        run(4, 1'b0, 100, cyc, acc, vcyc);
        check("echo_valid_cycles", vcyc, 4);
        check("echo_accepts", acc, 4);
        check("echo_ready_cycle", cyc, 6);
        check("echo_ready", ready, 1);
        check("echo_error", error, 0);
        check("echo_state", dbg_state, 2);

        // Masked mismatch on vector 2: response 0x0F vs expected 0xFF, upper nibble checked.
        load(2, 32'h0000_000F, 32'h0000_00FF, 32'h0000_00F0);
        run(4, 1'b0, 100, cyc, acc, vcyc);
        check("mm_cycle", cyc, 5);
        check("mm_error", error, 1);
        check("mm_ready", ready, 0);
        check("mm_fail_idx", fail_idx, 2);
        check("mm_fail_code", fail_code, 1);
        check("mm_valid_low", dut_valid, 0);
        @(negedge clk);
        check("mm_done_valid_low", dut_valid, 0);
        check("mm_done_fail_idx", fail_idx, 2);
        check("mm_done_fail_code", fail_code, 1);

        load(2, 32'h0000_000F, 32'h0000_00FF, 32'h0000_000F);
        run(4, 1'b0, 100, cyc, acc, vcyc);
        check("mask_pass_ready", ready, 1);
        check("mask_pass_error", error, 0);
        check("mask_pass_cycle", cyc, 6);

        // dut_ready alternating: issues in odd cycles, last check at the edge ending cycle 16.
        run(8, 1'b1, 200, cyc, acc, vcyc);
        check("toggle_accepts", acc, 8);
        check("toggle_ready", ready, 1);
        check("toggle_error", error, 0);
        check("toggle_cycle", cyc, 17);

        // One response then silence: 64 idle cycles (3..66), error visible in cycle 67.
        resp_limit = 1;
        run(4, 1'b0, 200, cyc, acc, vcyc);
        resp_limit = 1000;
        check("to_cycle", cyc, 67);
        check("to_error", error, 1);
        check("to_ready", ready, 0);
        check("to_fail_code", fail_code, 2);
        check("to_fail_idx", fail_idx, 1);

        // Response with nothing yet accepted.
        @(negedge clk);
        num_vec = IW'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        check("extra_error", error, 1);
        check("extra_fail_code", fail_code, 3);
        check("extra_fail_idx", fail_idx, 0);
        check("extra_valid_low", dut_valid, 0);
        @(negedge clk);
        check("done_ignore_code", fail_code, 3);
        check("done_ignore_ready", ready, 0);

        // Empty run.
        run(0, 1'b0, 20, cyc, acc, vcyc);
        check("zero_ready", ready, 1);
        check("zero_error", error, 0);
        check("zero_valid_cycles", vcyc, 0);
        check("zero_cycle", cyc, 2);

        // Reset while vector 3 is on the issue channel.
        @(negedge clk);
        num_vec = IW'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run_v3_stim", dut_stim, stim_tbl[3]);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", dut_valid, 0);
        check("mid_rst_stim", dut_stim, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_fail_idx", fail_idx, 0);
        check("mid_rst_fail_code", fail_code, 0);
        check("mid_rst_state", dbg_state, 0);
        reset = 1'b0;
        run(4, 1'b0, 100, cyc, acc, vcyc);
        check("restart_ready", ready, 1);
        check("restart_error", error, 0);
        check("restart_cycle", cyc, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
